// File: rtl/capture_scheduler.sv
// capture_scheduler: sequences frame captures on two cameras in rounds.
// Each round triggers every latched camera once (cam0 first). Rounds can
// repeat at a fixed period, stop early, or flag cameras that never answer.
module capture_scheduler #(
    parameter logic [23:0] TIMEOUT  = 24'd1000000,
    parameter int          PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          cam_enable,
    input  logic                continuous,
    input  logic [PERIOD_W-1:0] frame_period,
    input  logic                cam0_frame_capture_done,
    input  logic                cam1_frame_capture_done,
    input  logic                cam0_fifo_afull,
    input  logic                cam1_fifo_afull,
    output logic                cam0_frame_capture_start,
    output logic                cam1_frame_capture_start,
    output logic                busy,
    output logic                active_cam,
    output logic [15:0]         cam0_frame_count,
    output logic [15:0]         cam1_frame_count,
    output logic [1:0]          timeout_err,
    output logic                round_done
);

    typedef enum logic [1:0] {IDLE, WAIT_FIFO, CAPTURE, PERIOD_WAIT} state_e;

    localparam logic [PERIOD_W-1:0] P_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [1:0]          cam_en_q, cam_en_d;
    logic                cont_q, cont_d;
    logic                stop_pend_q, stop_pend_d;
    logic [PERIOD_W-1:0] period_q, period_d, period_lim;
    logic [23:0]         tmo_q, tmo_d;
    logic                active_d, start0_d, start1_d, round_done_d;
    logic [15:0]         cnt0_d, cnt1_d;
    logic [1:0]          err_d;
    logic                do_sel, sel_cam, sel_afull, act_done, timed_out;

    assign busy = (state_q != IDLE);

    // A zero period behaves like a period of one cycle.
    assign period_lim = (frame_period == '0) ? '0 : frame_period - P_ONE;

    // Next-state and next-output logic for the scheduler.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d      = state_q;
        cam_en_d     = cam_en_q;
        cont_d       = cont_q;
        active_d     = active_cam;
        cnt0_d       = cam0_frame_count;
        cnt1_d       = cam1_frame_count;
        err_d        = timeout_err;
        tmo_d        = tmo_q;
        start0_d     = 1'b0;
        start1_d     = 1'b0;
        round_done_d = 1'b0;
        do_sel       = 1'b0;
        sel_cam      = 1'b0;
        stop_pend_d  = stop_pend_q | (stop && state_q != IDLE);
        period_d     = (state_q != IDLE && period_q != '1) ? period_q + P_ONE : period_q;
        act_done     = active_cam ? cam1_frame_capture_done : cam0_frame_capture_done;
        timed_out    = (tmo_q == TIMEOUT - 24'd1);

        case (state_q)
            IDLE: begin
                if (start && cam_enable != 2'b00) begin
                    cam_en_d    = cam_enable;
                    cont_d      = continuous;
                    err_d       = 2'b00;
                    period_d    = '0;
                    stop_pend_d = stop;
                    do_sel      = 1'b1;
                    sel_cam     = !cam_enable[0];
                end
            end
            WAIT_FIFO: begin
                if (stop || stop_pend_q) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else begin
                    // Re-select the same camera; it launches once afull drops.
                    do_sel  = 1'b1;
                    sel_cam = active_cam;
                end
            end
            CAPTURE: begin
                if (act_done || timed_out) begin
                    // A done that coincides with the timeout still counts as done.
                    if (act_done) begin
                        if (active_cam) cnt1_d = cam1_frame_count + 16'd1;
                        else            cnt0_d = cam0_frame_count + 16'd1;
                    end else begin
                        err_d[active_cam] = 1'b1;
                    end
                    if (stop || stop_pend_q) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else if (!active_cam && cam_en_q[1]) begin
                        do_sel  = 1'b1;
                        sel_cam = 1'b1;
                    end else begin
                        round_done_d = 1'b1;
                        state_d      = cont_q ? PERIOD_WAIT : IDLE;
                    end
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            PERIOD_WAIT: begin
                if (stop || stop_pend_q) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else if (period_q >= period_lim) begin
                    period_d = '0;
                    do_sel   = 1'b1;
                    sel_cam  = !cam_en_q[0];
                end
            end
            default: state_d = IDLE;
        endcase

        // Common camera selection: launch now if its FIFO has room, else wait.
        sel_afull = sel_cam ? cam1_fifo_afull : cam0_fifo_afull;
        if (do_sel) begin
            active_d = sel_cam;
            if (sel_afull) begin
                state_d = WAIT_FIFO;
            end else begin
                state_d  = CAPTURE;
                tmo_d    = '0;
                start0_d = !sel_cam;
                start1_d = sel_cam;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments only, so all registers update together.
        if (!reset) begin
            state_q                  <= IDLE;
            cam_en_q                 <= 2'b00;
            cont_q                   <= 1'b0;
            stop_pend_q              <= 1'b0;
            period_q                 <= '0;
            tmo_q                    <= '0;
            active_cam               <= 1'b0;
            cam0_frame_capture_start <= 1'b0;
            cam1_frame_capture_start <= 1'b0;
            cam0_frame_count         <= '0;
            cam1_frame_count         <= '0;
            timeout_err              <= 2'b00;
            round_done               <= 1'b0;
        end else begin
            state_q                  <= state_d;
            cam_en_q                 <= cam_en_d;
            cont_q                   <= cont_d;
            stop_pend_q              <= stop_pend_d;
            period_q                 <= period_d;
            tmo_q                    <= tmo_d;
            active_cam               <= active_d;
            cam0_frame_capture_start <= start0_d;
            cam1_frame_capture_start <= start1_d;
            cam0_frame_count         <= cnt0_d;
            cam1_frame_count         <= cnt1_d;
            timeout_err              <= err_d;
            round_done               <= round_done_d;
        end
    end

endmodule

// File: tb/tb_capture_scheduler.sv
// tb_capture_scheduler: table-driven rounds plus hand-written sequences for
// continuous mode, stop and reset. Expected start/round_done events are queued
// with their cycle numbers when stimulus is driven and matched as they appear.
module tb_capture_scheduler;

    localparam int TB_TIMEOUT = 16;

    typedef enum logic [1:0] {EV_START0, EV_START1, EV_RDONE} ev_kind_e;
    typedef struct { ev_kind_e kind; int cyc; } ev_t;
    typedef struct {
        logic [1:0] en;
        int         afull0_cyc;
        int         d0;
        int         d1;
        int         inc0;
        int         inc1;
        logic [1:0] exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, stop, continuous;
    logic        cam0_done, cam1_done, cam0_afull, cam1_afull;
    logic [1:0]  cam_enable;
    logic [23:0] frame_period;
    logic        cam0_start, cam1_start, busy, active_cam, round_done;
    logic [15:0] cam0_count, cam1_count;
    logic [1:0]  timeout_err;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    int   done_dly0 = -1;
    int   done_dly1 = -1;
    ev_t  exp_q[$];
    vec_t vecs[8];

    capture_scheduler #(.TIMEOUT(24'd16), .PERIOD_W(24)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .stop                     (stop),
        .cam_enable               (cam_enable),
        .continuous               (continuous),
        .frame_period             (frame_period),
        .cam0_frame_capture_done  (cam0_done),
        .cam1_frame_capture_done  (cam1_done),
        .cam0_fifo_afull          (cam0_afull),
        .cam1_fifo_afull          (cam1_afull),
        .cam0_frame_capture_start (cam0_start),
        .cam1_frame_capture_start (cam1_start),
        .busy                     (busy),
        .active_cam               (active_cam),
        .cam0_frame_count         (cam0_count),
        .cam1_frame_count         (cam1_count),
        .timeout_err              (timeout_err),
        .round_done               (round_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input ev_kind_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic match_event(input ev_kind_e kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required none", kind.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check({"event_kind_", e.kind.name()}, 32'(kind), 32'(e.kind));
            check({"event_cycle_", e.kind.name()}, cyc, e.cyc);
        end
    endtask

    // Event monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (cam0_start) match_event(EV_START0);
        if (cam1_start) match_event(EV_START1);
        if (round_done) match_event(EV_RDONE);
    end

    // Camera models: answer a start pulse with done after a programmed delay.
    initial begin : cam0_model
        cam0_done = 1'b0;
        forever begin
            @(negedge clk);
            if (cam0_start && done_dly0 >= 0) begin
                repeat (done_dly0) @(negedge clk);
                cam0_done = 1'b1;
                @(negedge clk);
                cam0_done = 1'b0;
            end
        end
    end

    initial begin : cam1_model
        cam1_done = 1'b0;
        forever begin
            @(negedge clk);
            if (cam1_start && done_dly1 >= 0) begin
                repeat (done_dly1) @(negedge clk);
                cam1_done = 1'b1;
                @(negedge clk);
                cam1_done = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_within_bound", busy, 1'b0);
    endtask

    // One non-continuous round described by a table record.
    task automatic run_vec(input int idx, input vec_t v);
        int k, t, p, d;
        @(negedge clk);
        cam_enable = v.en;
        continuous = 1'b0;
        done_dly0  = v.d0;
        done_dly1  = v.d1;
        cam0_afull = (v.afull0_cyc > 0);
        start      = 1'b1;
        k = cyc + 1;
        t = k;
        if (v.en != 2'b00) begin
            for (int c = 0; c < 2; c++) begin
                if (v.en[c]) begin
                    p = t + ((c == 0) ? v.afull0_cyc : 0);
                    push((c == 0) ? EV_START0 : EV_START1, p);
                    d = (c == 0) ? v.d0 : v.d1;
                    t = (d >= 0) ? p + 1 + d : p + TB_TIMEOUT;
                end
            end
            push(EV_RDONE, t);
        end
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_after_start", idx), busy, (v.en != 2'b00));
        if (v.afull0_cyc > 0) begin
            repeat (v.afull0_cyc - 1) @(negedge clk);
            cam0_afull = 1'b0;
        end
        wait_idle(200);
        repeat (3) @(negedge clk);
        exp_cnt0 += v.inc0;
        exp_cnt1 += v.inc1;
        check($sformatf("v%0d_events_left", idx), exp_q.size(), 0);
        check($sformatf("v%0d_cam0_count", idx), cam0_count, exp_cnt0);
        check($sformatf("v%0d_cam1_count", idx), cam1_count, exp_cnt1);
        check($sformatf("v%0d_timeout_err", idx), timeout_err, v.exp_err);
        if (v.en != 2'b00) check($sformatf("v%0d_active_cam", idx), active_cam, v.en[1]);
    endtask

    // Continuous cam0-only rounds, then stop either in PERIOD_WAIT or mid-frame.
    task automatic run_cont(input int fp, input int d, input int nround, input bit stop_in_wait);
        int k, s, rd, fp_eff, stop_cyc;
        fp_eff = (fp == 0) ? 1 : fp;
        @(negedge clk);
        cam0_afull   = 1'b0;
        continuous   = 1'b1;
        frame_period = 24'(fp);
        done_dly0    = d;
        cam_enable   = 2'b01;
        start        = 1'b1;
        k  = cyc + 1;
        s  = k;
        rd = s + 1 + d;
        for (int r = 0; r < nround; r++) begin
            rd = s + 1 + d;
            push(EV_START0, s);
            if (r < nround - 1 || stop_in_wait) push(EV_RDONE, rd);
            if (r < nround - 1) s = (s + fp_eff > rd + 1) ? s + fp_eff : rd + 1;
        end
        stop_cyc = stop_in_wait ? rd + 2 : s + 2;
        @(negedge clk);
        start      = 1'b0;
        continuous = 1'b0;
        while (cyc < stop_cyc) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        if (stop_in_wait) begin
            check($sformatf("p%0d_stop_wait_idle", fp), busy, 1'b0);
        end else begin
            while (cyc < rd - 1) @(negedge clk);
            check($sformatf("p%0d_stop_finishes_frame", fp), busy, 1'b1);
        end
        wait_idle(100);
        repeat (2 * fp_eff + 20) @(negedge clk);
        exp_cnt0 += nround;
        check($sformatf("p%0d_events_left", fp), exp_q.size(), 0);
        check($sformatf("p%0d_cam0_count", fp), cam0_count, exp_cnt0);
        check($sformatf("p%0d_idle", fp), busy, 1'b0);
    endtask

    initial begin
        int k;
        reset = 1'b0; start = 1'b0; stop = 1'b0; cam_enable = 2'b00; continuous = 1'b0;
        frame_period = 24'd0; cam0_afull = 1'b0; cam1_afull = 1'b0;

        //           en     afull0 d0  d1  inc0 inc1 err
        vecs[0] = '{2'b11,  0,     4,  2,  1,   1,   2'b00}; // both cams, done/done
        vecs[1] = '{2'b10,  0,     0, -1,  0,   0,   2'b10}; // cam1 times out
        vecs[2] = '{2'b01,  7,     3,  0,  1,   0,   2'b00}; // afull back-pressure, err cleared
        vecs[3] = '{2'b01, 20,     2,  0,  1,   0,   2'b00}; // long afull, no timeout
        vecs[4] = '{2'b11,  0,    -1,  0,  0,   1,   2'b01}; // cam0 timeout, cam1 immediate done
        vecs[5] = '{2'b00,  0,     0,  0,  0,   0,   2'b01}; // ignored start keeps err
        vecs[6] = '{2'b11,  0,    15,  5,  1,   1,   2'b00}; // done on the timeout edge
        vecs[7] = '{2'b10,  5,     0,  3,  0,   1,   2'b00}; // cam0 afull irrelevant

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_starts", {cam0_start, cam1_start}, 2'b00);
        check("rst_counts", {cam0_count, cam1_count}, 32'd0);
        check("rst_err", timeout_err, 2'b00);
        check("rst_round_done", round_done, 1'b0);
        check("rst_active_cam", active_cam, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        run_cont(40, 9, 3, 1'b1);
        run_cont(4, 9, 3, 1'b0);
        run_cont(0, 9, 2, 1'b0);

        // Stop mid-CAPTURE on cam0 of a two-camera round.
        @(negedge clk);
        cam_enable = 2'b11; continuous = 1'b0; done_dly0 = 6; done_dly1 = 0; start = 1'b1;
        k = cyc + 1;
        push(EV_START0, k);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy_until_done", busy, 1'b1);
        wait_idle(100);
        repeat (20) @(negedge clk);
        exp_cnt0++;
        check("stop_events_left", exp_q.size(), 0);
        check("stop_cam0_count", cam0_count, exp_cnt0);
        check("stop_cam1_count", cam1_count, exp_cnt1);

        // Reset asserted mid-CAPTURE, then a fresh round right after release.
        @(negedge clk);
        cam_enable = 2'b01; done_dly0 = -1; start = 1'b1;
        k = cyc + 1;
        push(EV_START0, k);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_starts", {cam0_start, cam1_start}, 2'b00);
        check("mid_rst_counts", {cam0_count, cam1_count}, 32'd0);
        check("mid_rst_err", timeout_err, 2'b00);
        check("mid_rst_outs", {round_done, active_cam}, 2'b00);
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1; done_dly0 = 2; start = 1'b1;
        k = cyc + 1;
        push(EV_START0, k);
        push(EV_RDONE, k + 3);
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);
        repeat (5) @(negedge clk);
        exp_cnt0++;
        check("post_rst_events_left", exp_q.size(), 0);
        check("post_rst_cam0_count", cam0_count, exp_cnt0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/capture_scheduler.md
CAPTURE_SCHEDULER -- requirements
Module: capture_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd1000000: maximum cycles from a capture start pulse to its frame done.
REQ-002 SHALL have parameter PERIOD_W, default 24: width of frame_period and of the period counter.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset; 0 = reset asserted.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a round, or a continuous run.
REQ-006 SHALL have port stop, input, 1: one-cycle request to end operation.
REQ-007 SHALL have port cam_enable, input, 2: bit0 = cam0, bit1 = cam1.
REQ-008 SHALL have port continuous, input, 1: 1 = repeat rounds until stopped.
REQ-009 SHALL have port frame_period, input, PERIOD_W: cycles from one round start to the next round start.
REQ-010 SHALL have ports cam0_frame_capture_done and cam1_frame_capture_done, input, 1 each: frame-complete pulses.
REQ-011 SHALL have ports cam0_fifo_afull and cam1_fifo_afull, input, 1 each: back-pressure.
REQ-012 SHALL have ports cam0_frame_capture_start and cam1_frame_capture_start, output, 1 each: one-cycle registered pulses.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port active_cam, output, 1: camera currently scheduled.
REQ-015 SHALL have ports cam0_frame_count and cam1_frame_count, output, 16 each: completed frames.
REQ-016 SHALL have port timeout_err, output, 2: sticky per-camera timeout flags.
REQ-017 SHALL have port round_done, output, 1: one-cycle pulse at the end of each round.

Function
REQ-018 SHALL implement states IDLE, WAIT_FIFO, CAPTURE, PERIOD_WAIT.
REQ-019 IDLE: when start=1 and cam_enable!=0 at edge k, SHALL latch cam_enable, latch continuous, clear timeout_err, and reset the period counter to 0.
  - Then select cam0 if enabled, otherwise cam1.
REQ-020 IDLE: start with cam_enable==0 SHALL be ignored; start in any non-IDLE state SHALL be ignored.
REQ-021 On selecting a camera with its afull=0, SHALL raise that camera's frame_capture_start for the single cycle after the deciding edge and enter CAPTURE.
  - Example: start at edge k -> pulse from k+1 to k+2.
REQ-022 On selecting a camera with its afull=1, SHALL enter WAIT_FIFO.
  - Pulse issues at the edge after afull is sampled low.
  - No timeout applies while in WAIT_FIFO.
REQ-023 CAPTURE: SHALL sample only the active camera's done.
  - The inactive camera's done is ignored.
  - Done in the start-pulse cycle is accepted.
REQ-024 Done sampled at edge j: SHALL increment that camera's frame_count, which wraps 0xFFFF->0x0000.
  - If the other latched camera remains in the round, select it at edge j, so its start pulse falls in j+1..j+2.
  - Otherwise end the round.
REQ-025 Timeout counter SHALL clear at each start pulse.
  - If no done is sampled within TIMEOUT cycles, SHALL set timeout_err[active_cam] and advance as in REQ-024, without incrementing the frame count.
REQ-026 Done and timeout on the same edge SHALL count as done.
REQ-027 Round end SHALL pulse round_done for one cycle.
  - Latched continuous=0 -> IDLE.
  - Latched continuous=1 -> PERIOD_WAIT.
REQ-028 Period counter SHALL increment every cycle from round start and saturate at all-ones.
REQ-029 PERIOD_WAIT: when counter >= frame_period-1, SHALL start a new round, reset the counter, and select the camera per REQ-019.
  - If the round already overran frame_period, the new round starts on the edge after round_done.
  - frame_period=0 SHALL be treated as 1.
REQ-030 stop SHALL set stop_pending.
  - In CAPTURE: finish the current frame (done or timeout), count/flag it, then go to IDLE with no round_done.
  - In WAIT_FIFO or PERIOD_WAIT: go to IDLE at the next edge, with no start pulse.
  - stop in IDLE has no effect.
  - start and stop on the same edge in IDLE: start wins, stop_pending set.
REQ-031 active_cam SHALL be valid from the start pulse until the next camera is selected.

Reset
REQ-032 reset=0 SHALL, asynchronously and in any state (including mid-capture), force IDLE and drive every output low.
  - Clears counts, timeout_err, stop_pending, period counter and the timeout counter.
REQ-033 Deassertion SHALL take effect synchronously: the first start is honoured at the first rising edge with reset=1.

Verification
REQ-034 Bench SHALL set TIMEOUT=16 and, after reset, pulse start with cam_enable=2'b11, continuous=0.
  - Required: cam0 start pulse 1 cycle later.
  - Done at +5 -> cam1 start next cycle; cam1 done -> round_done, IDLE.
  - Counts 1/1.
REQ-035 Bench SHALL hold cam1_frame_capture_done low with cam_enable=2'b10.
  - Required: timeout_err=2'b10 after 16 cycles, cam1 count 0, round_done, IDLE.
REQ-036 Bench SHALL set cam0_fifo_afull=1 at start and release it 7 cycles later.
  - Required: no pulse while afull=1; cam0 start the edge after release; no timeout flagged.
REQ-037 Bench SHALL run continuous=1, frame_period=40, cam0 only, done after 10 cycles.
  - Required: successive cam0 start pulses exactly 40 cycles apart.
  - With frame_period=4 instead, starts occur back-to-back after round_done.
REQ-038 Bench SHALL pulse stop mid-CAPTURE, then inject done.
  - Required: count increments, IDLE, no round_done, no further starts.
REQ-039 Bench SHALL assert reset=0 mid-CAPTURE.
  - Required: busy, all outputs and counts 0 immediately; cam0 start 1 cycle after the first start following reset release.
